// File: rtl/proc_in_multi_debounce.sv
// Multi-channel asymmetric debounce plugin between frontend and user sides.
// Each channel: synchroniser, stable-level FSM, edge pulses, glitch counter.
module proc_in_multi_debounce #(
  parameter int CHANNELS    = 4,
  parameter int RISE_TICKS  = 125000,
  parameter int FALL_TICKS  = 125000,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0,
  parameter int GLITCH_W    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         plugin_enable,
  output logic [CHANNELS-1:0]          internal_out,
  input  logic [CHANNELS-1:0]          internal_in,
  input  logic [CHANNELS-1:0]          virtual_out,
  output logic [CHANNELS-1:0]          virtual_in,
  output logic [CHANNELS-1:0]          rise_pulse,
  output logic [CHANNELS-1:0]          fall_pulse,
  output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt,
  input  logic                         glitch_clr,
  output logic                         output_enable,
  output logic                         input_enable
);

  localparam int MAXT = (RISE_TICKS > FALL_TICKS) ?
                        RISE_TICKS : FALL_TICKS;
  localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;

  typedef enum logic [1:0] {
    STABLE_0,
    STABLE_1,
    CHECK_0,
    CHECK_1
  } state_t;

  if (RISE_TICKS < 2) begin : g_bad_rise
    $error("RISE_TICKS must be >= 2");
  end
  if (FALL_TICKS < 2) begin : g_bad_fall
    $error("FALL_TICKS must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  assign internal_out  = virtual_out;
  assign output_enable = 1'b1;
  assign input_enable  = 1'b1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   out_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [GLITCH_W-1:0]    glitch;
    logic                   glitch_hit;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], internal_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state  <= RESET_LEVEL ? STABLE_1 : STABLE_0;
        cnt    <= '0;
        out_q  <= RESET_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (!plugin_enable) begin
          state <= out_q ? STABLE_1 : STABLE_0;
          cnt   <= '0;
        end else begin
          unique case (state)
            STABLE_0: begin
              if (s) begin
                state <= CHECK_1;
                cnt   <= CW'(RISE_TICKS - 1);
              end
            end
            STABLE_1: begin
              if (!s) begin
                state <= CHECK_0;
                cnt   <= CW'(FALL_TICKS - 1);
              end
            end
            CHECK_1: begin
              if (!s) begin
                state <= STABLE_0;
                cnt   <= '0;
              end else if (cnt == CW'(1)) begin
                state  <= STABLE_1;
                cnt    <= '0;
                out_q  <= 1'b1;
                rise_q <= 1'b1;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            CHECK_0: begin
              if (s) begin
                state <= STABLE_1;
                cnt   <= '0;
              end else if (cnt == CW'(1)) begin
                state  <= STABLE_0;
                cnt    <= '0;
                out_q  <= 1'b0;
                fall_q <= 1'b1;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          endcase
        end
      end
    end

    // An aborted check is one where s returns to the committed level.
    assign glitch_hit = plugin_enable &&
                        (((state == CHECK_1) && !s) ||
                         ((state == CHECK_0) && s));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        glitch <= '0;
      end else if (glitch_clr) begin
        glitch <= '0;
      end else if (glitch_hit && !(&glitch)) begin
        glitch <= glitch + 1'b1;
      end
    end

    assign virtual_in[i] = out_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign glitch_cnt[i*GLITCH_W +: GLITCH_W] = glitch;
  end

endmodule

// File: tb/tb_proc_in_multi_debounce.sv
// Randomised bench for proc_in_multi_debounce against a run-length model.
// Model counts consecutive off-level samples instead of tracking FSM states.
module tb_proc_in_multi_debounce;

  localparam int CH   = 2;
  localparam int RISE = 4;
  localparam int FALL = 6;
  localparam int SYNC = 2;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              plugin_enable = 1'b1;
  logic [CH-1:0]     internal_out;
  logic [CH-1:0]     internal_in = '0;
  logic [CH-1:0]     virtual_out = '0;
  logic [CH-1:0]     virtual_in;
  logic [CH-1:0]     rise_pulse;
  logic [CH-1:0]     fall_pulse;
  logic [CH*GW-1:0]  glitch_cnt;
  logic              glitch_clr = 1'b0;
  logic              output_enable;
  logic              input_enable;

  int n_cmp = 0;
  int n_err = 0;

  proc_in_multi_debounce #(
    .CHANNELS    (CH),
    .RISE_TICKS  (RISE),
    .FALL_TICKS  (FALL),
    .SYNC_STAGES (SYNC),
    .RESET_LEVEL (1'b0),
    .GLITCH_W    (GW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .plugin_enable (plugin_enable),
    .internal_out  (internal_out),
    .internal_in   (internal_in),
    .virtual_out   (virtual_out),
    .virtual_in    (virtual_in),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .glitch_cnt    (glitch_cnt),
    .glitch_clr    (glitch_clr),
    .output_enable (output_enable),
    .input_enable  (input_enable)
  );

  always #5 clock = ~clock;

  // Reference model: delay line plus run length of samples away from out.
  bit m_dly [CH][SYNC];
  bit m_out [CH];
  int m_run [CH];
  int m_gl  [CH];
  bit m_rp  [CH];
  bit m_fp  [CH];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        for (int k = 0; k < SYNC; k++) m_dly[i][k] = 1'b0;
        m_out[i] = 1'b0;
        m_run[i] = 0;
        m_gl[i]  = 0;
        m_rp[i]  = 1'b0;
        m_fp[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit s;
        bit inc;
        int t;
        s = m_dly[i][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
        m_dly[i][0] = internal_in[i];
        m_rp[i] = 1'b0;
        m_fp[i] = 1'b0;
        inc = 1'b0;
        if (!plugin_enable) begin
          m_run[i] = 0;
        end else if (s != m_out[i]) begin
          t = m_out[i] ? FALL : RISE;
          m_run[i]++;
          if (m_run[i] == t) begin
            m_out[i] = s;
            m_run[i] = 0;
            if (s) m_rp[i] = 1'b1;
            else   m_fp[i] = 1'b1;
          end
        end else begin
          inc = (m_run[i] > 0);
          m_run[i] = 0;
        end
        if (glitch_clr) m_gl[i] = 0;
        else if (inc && m_gl[i] < GMAX) m_gl[i]++;
      end
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0]    ev;
    logic [CH-1:0]    er;
    logic [CH-1:0]    ef;
    logic [CH*GW-1:0] eg;
    for (int i = 0; i < CH; i++) begin
      ev[i] = m_out[i];
      er[i] = m_rp[i];
      ef[i] = m_fp[i];
      eg[i*GW +: GW] = GW'(m_gl[i]);
    end
    check("virtual_in", 32'(virtual_in), 32'(ev));
    check("rise_pulse", 32'(rise_pulse), 32'(er));
    check("fall_pulse", 32'(fall_pulse), 32'(ef));
    check("glitch_cnt", 32'(glitch_cnt), 32'(eg));
    check("enables", {30'd0, output_enable, input_enable}, 32'd3);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    check_all();
    virtual_out = CH'($urandom);
    #1;
    check("internal_out", 32'(internal_out), 32'(virtual_out));
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state, then quiet inputs.
    ticks(3);
    check("rst_vin", 32'(virtual_in), 32'd0);
    check("rst_gl", 32'(glitch_cnt), 32'd0);
    reset = 1'b1;
    ticks(20);
    check("idle_vin", 32'(virtual_in), 32'd0);

    // Rise on channel 0 only.
    internal_in[0] = 1'b1;
    ticks(12);
    check("rise_ch0", 32'(virtual_in), 32'd1);

    // Repeated short highs saturate the glitch counter.
    internal_in[0] = 1'b0;
    ticks(12);
    for (int r = 0; r < 300; r++) begin
      internal_in[0] = 1'b1;
      ticks(3);
      internal_in[0] = 1'b0;
      ticks(3);
    end
    check("glitch_sat", 32'(glitch_cnt[GW-1:0]), 32'(GMAX));
    check("glitch_vin", 32'(virtual_in[0]), 32'd0);
    internal_in[0] = 1'b1;
    ticks(3);
    internal_in[0] = 1'b0;
    glitch_clr = 1'b1;
    ticks(4);
    glitch_clr = 1'b0;
    check("glitch_clr", 32'(glitch_cnt[GW-1:0]), 32'd0);

    // Channel 1: rise, short low (glitch), then a committed fall.
    internal_in[1] = 1'b1;
    ticks(10);
    internal_in[1] = 1'b0;
    ticks(5);
    internal_in[1] = 1'b1;
    ticks(6);
    check("low5_vin", 32'(virtual_in[1]), 32'd1);
    check("low5_gl", 32'(glitch_cnt[GW +: GW]), 32'd1);
    internal_in[1] = 1'b0;
    ticks(12);
    check("fall_ch1", 32'(virtual_in[1]), 32'd0);

    // Disable mid-rise; qualification restarts on re-enable.
    internal_in[0] = 1'b1;
    ticks(4);
    plugin_enable = 1'b0;
    ticks(6);
    check("dis_hold", 32'(virtual_in[0]), 32'd0);
    plugin_enable = 1'b1;
    ticks(3);
    check("reen_3", 32'(virtual_in[0]), 32'd0);
    tick();
    check("reen_4", 32'(virtual_in[0]), 32'd1);
    check("reen_rp", 32'(rise_pulse[0]), 32'd1);

    // Async reset in the middle of a fall check.
    internal_in[0] = 1'b0;
    ticks(4);
    #2;
    reset = 1'b0;
    #1;
    check("arst_vin", 32'(virtual_in), 32'd0);
    check("arst_gl", 32'(glitch_cnt), 32'd0);
    check("arst_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
    internal_in = '0;
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // Randomised traffic on all controls.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(5) == 0) internal_in[i] = ~internal_in[i];
      if ($urandom_range(39) == 0) plugin_enable = ~plugin_enable;
      glitch_clr = ($urandom_range(49) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
